// File: rtl/fifo_stream_reader_if.sv
// Read-port and stream signals of fifo_stream_reader, bundled as one interface.
// The master side is the reader; the slave side is the FIFO plus the stream sink.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_fifo_empty;
   logic [DATA_WIDTH-1:0] i_fifo_rd_data;
   logic                  o_fifo_rd_en;
   logic                  o_m_valid;
   logic [DATA_WIDTH-1:0] o_m_data;
   logic                  i_m_ready;

   modport master (
      input  i_fifo_empty,
      input  i_fifo_rd_data,
      input  i_m_ready,
      output o_fifo_rd_en,
      output o_m_valid,
      output o_m_data
   );

   modport slave (
      output i_fifo_empty,
      output i_fifo_rd_data,
      output i_m_ready,
      input  o_fifo_rd_en,
      input  o_m_valid,
      input  o_m_data
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO (1-cycle read latency) into a small circular skid buffer
// and presents the words in order as a valid/ready stream.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int SKID_DEPTH = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   output logic [CNT_WIDTH-1:0] o_pop_count,
   fifo_stream_reader_if.master rd_bus
);
   localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   localparam int SUM_W = OCC_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
   localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(SKID_DEPTH);

   generate
      if (SKID_DEPTH < 2) begin : g_bad_depth
         $error("fifo_stream_reader: SKID_DEPTH must be at least 2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] buf_q [SKID_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;
   logic                  rd_en;
   logic                  capture;
   logic                  pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Reserve a slot for every word already requested so the buffer can never overflow;
   // i_m_ready is deliberately kept out of this path.
   always_comb begin
      rd_en = !i_rst && !i_flush && !rd_bus.i_fifo_empty &&
              (({1'b0, occ_q} + SUM_W'(inflight_q)) < DEPTH_SUM);
   end

   always_comb begin
      capture = inflight_q && !i_flush;
      pop     = (occ_q != '0) && rd_bus.i_m_ready;
   end

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      occ_d       = occ_q;
      pop_count_d = pop_count_q;
      inflight_d  = rd_en;

      // A handshake on a flush edge still completes, so it is counted regardless.
      if (pop) begin
         pop_count_d = pop_count_q + 1'b1;
      end

      if (i_flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (pop) begin
            head_d = ptr_inc(head_q);
         end
         if (capture) begin
            tail_d = ptr_inc(tail_q);
         end
         if (capture && !pop) begin
            occ_d = occ_q + 1'b1;
         end else if (!capture && pop) begin
            occ_d = occ_q - 1'b1;
         end else begin
            occ_d = occ_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         occ_q       <= '0;
         inflight_q  <= 1'b0;
         pop_count_q <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         inflight_q  <= inflight_d;
         pop_count_q <= pop_count_d;
      end
   end

   // Entries are cleared on reset so o_m_data reads 0 until the first capture.
   generate
      for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               buf_q[gi] <= '0;
            end else if (capture && (tail_q == PTR_W'(gi))) begin
               buf_q[gi] <= rd_bus.i_fifo_rd_data;
            end
         end
      end
   endgenerate

   assign rd_bus.o_fifo_rd_en = rd_en;
   assign rd_bus.o_m_valid    = (occ_q != '0);
   assign rd_bus.o_m_data     = buf_q[head_q];
   assign o_pop_count         = pop_count_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural 16-deep FIFO in front, scoreboard queue behind.
module tb_fifo_stream_reader;
   localparam int DW = 8;
   localparam int SD = 3;
   localparam int CW = 5;
   localparam int FD = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [CW-1:0] pop_count;

   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) rd_if ();

   fifo_stream_reader #(
      .DATA_WIDTH(DW),
      .SKID_DEPTH(SD),
      .CNT_WIDTH (CW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_flush    (flush),
      .o_pop_count(pop_count),
      .rd_bus     (rd_if.master)
   );

   // Reference synchronous FIFO with registered read data.
   logic [DW-1:0] fmem [FD];
   int            fcnt = 0;
   int            frp  = 0;
   int            fwp  = 0;
   logic [DW-1:0] frd  = '0;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          f_rd, f_wr;

   assign f_rd = rd_if.o_fifo_rd_en && (fcnt > 0);
   assign f_wr = wr_en && ((fcnt < FD) || f_rd);
   assign rd_if.i_fifo_empty   = (fcnt == 0);
   assign rd_if.i_fifo_rd_data = frd;

   always @(posedge clk) begin
      if (rst) begin
         fcnt <= 0;
         frp  <= 0;
         fwp  <= 0;
         frd  <= '0;
      end else begin
         if (f_rd) begin
            frd <= fmem[frp];
            frp <= (frp + 1) % FD;
         end
         if (f_wr) begin
            fmem[fwp] <= wr_data;
            fwp       <= (fwp + 1) % FD;
         end
         fcnt <= fcnt + int'(f_wr) - int'(f_rd);
      end
   end

   logic [DW-1:0] exp_q [$];
   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;
   int            reads_total = 0;
   int            hs_total    = 0;
   int            hs_all      = 0;
   int            rd_first    = -1;
   int            valid_first = -1;
   logic [CW-1:0] exp_count   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
   endtask

   // Monitor: inputs change 3ns after posedge, so at negedge everything is settled
   // and describes what the next rising edge will do.
   always @(negedge clk) begin
      check("pop_count", 32'(pop_count), 32'(exp_count));
      if (rd_if.o_fifo_rd_en && (rd_if.i_fifo_empty || flush || rst)) begin
         fail_now("rd_en_illegal", "rd_en high while empty, flushing or in reset");
      end
      if (rst) begin
         exp_q.delete();
         exp_count   = '0;
         reads_total = 0;
         hs_total    = 0;
         hs_all      = 0;
      end else begin
         if (rd_if.o_fifo_rd_en) begin
            reads_total++;
            if (rd_first < 0) rd_first = cyc;
         end
         if (rd_if.o_m_valid && (valid_first < 0)) valid_first = cyc;
         if (rd_if.o_m_valid && rd_if.i_m_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("stream_data", $sformatf("unexpected word 0x%0h", rd_if.o_m_data));
            end else begin
               check("stream_data", 32'(rd_if.o_m_data), 32'(exp_q.pop_front()));
            end
            hs_total++;
            hs_all++;
            exp_count = exp_count + 1'b1;
         end
         // Every word requested from the FIFO but not yet handed over is lost.
         if (flush) begin
            while (hs_total < reads_total) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               hs_total++;
            end
         end
         if ((reads_total - hs_total) > SD) begin
            fail_now("skid_overrun", $sformatf("%0d words outstanding", reads_total - hs_total));
         end
      end
   end

   typedef struct {
      logic          rst;
      logic          flush;
      logic          ready;
      logic          wr;
      logic [DW-1:0] wr_data;
      logic          exp_rd_en;
      logic          exp_valid;
      logic          chk_data;
      logic [DW-1:0] exp_data;
      logic [CW-1:0] exp_count;
   } vec_t;

   vec_t vt [20];

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset(input int n);
      wr_en = 1'b0;
      flush = 1'b0;
      rst   = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic fifo_write(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((exp_q.size() == 0) && !rd_if.o_m_valid && (fcnt == 0)) && (n < max));
      if (!((exp_q.size() == 0) && !rd_if.o_m_valid && (fcnt == 0))) begin
         fail_now(name, $sformatf("not drained after %0d cycles, %0d words pending", max, exp_q.size()));
      end
   endtask

   task automatic wait_valid(input string name, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rd_if.o_m_valid && (n < max));
      if (!rd_if.o_m_valid) fail_now(name, "o_m_valid never rose");
   endtask

   initial begin
      rst             = 1'b1;
      flush           = 1'b0;
      wr_en           = 1'b0;
      wr_data         = '0;
      rd_if.i_m_ready = 1'b1;

      for (int i = 0; i < 10; i++) vt[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
      vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
      vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 5'd0};
      vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 5'd0};
      vt[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 5'd0};
      vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
      vt[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
      vt[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
      vt[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0};

      // Reset hold, single-word latency, stall, flush and reset, one vector per cycle.
      for (int i = 0; i < 20; i++) begin
         step();
         rst             = vt[i].rst;
         flush           = vt[i].flush;
         rd_if.i_m_ready = vt[i].ready;
         wr_en           = vt[i].wr;
         wr_data         = vt[i].wr_data;
         if (vt[i].wr) exp_q.push_back(vt[i].wr_data);
         @(negedge clk);
         check($sformatf("vec%0d_rd_en", i), 32'(rd_if.o_fifo_rd_en), 32'(vt[i].exp_rd_en));
         check($sformatf("vec%0d_valid", i), 32'(rd_if.o_m_valid), 32'(vt[i].exp_valid));
         check($sformatf("vec%0d_count", i), 32'(pop_count), 32'(vt[i].exp_count));
         if (vt[i].chk_data) check($sformatf("vec%0d_data", i), 32'(rd_if.o_m_data), 32'(vt[i].exp_data));
      end
      step();
      wr_en = 1'b0;

      // Three words streamed with ready held high.
      do_reset(1);
      rd_if.i_m_ready = 1'b1;
      rd_first        = -1;
      valid_first     = -1;
      fifo_write(8'h11);
      fifo_write(8'h22);
      fifo_write(8'h33);
      wait_drain("t2_drain", 30);
      check("t2_latency", 32'(valid_first - rd_first), 32'd2);
      check("t2_count", 32'(pop_count), 32'd3);
      check("t2_empty", 32'(rd_if.i_fifo_empty), 32'd1);
      check("t2_valid_after", 32'(rd_if.o_m_valid), 32'd0);

      // Full FIFO behind a stalled sink, then back-to-back drain.
      step();
      do_reset(1);
      rd_if.i_m_ready = 1'b0;
      for (int i = 0; i < 16; i++) fifo_write(8'(i));
      repeat (20) step();
      @(negedge clk);
      check("t3_rd_pulses", 32'(reads_total), 32'd3);
      check("t3_hold_data", 32'(rd_if.o_m_data), 32'h00);
      check("t3_hold_valid", 32'(rd_if.o_m_valid), 32'd1);
      check("t3_fifo_left", 32'(fcnt), 32'd13);
      step();
      rd_if.i_m_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check($sformatf("t3_tput%0d", k), 32'(rd_if.o_m_valid), 32'd1);
      end
      wait_drain("t3_drain", 20);
      check("t3_count", 32'(pop_count), 32'd16);
      check("t3_empty", 32'(rd_if.i_fifo_empty), 32'd1);

      // Flush with three words buffered and the sink stalled.
      step();
      do_reset(1);
      rd_if.i_m_ready = 1'b0;
      for (int i = 0; i < 16; i++) fifo_write(8'(i));
      repeat (20) step();
      @(negedge clk);
      check("t5_pre_valid", 32'(rd_if.o_m_valid), 32'd1);
      step();
      flush = 1'b1;
      @(negedge clk);
      check("t5_rd_en_flush", 32'(rd_if.o_fifo_rd_en), 32'd0);
      step();
      flush = 1'b0;
      @(negedge clk);
      check("t5_valid_after_flush", 32'(rd_if.o_m_valid), 32'd0);
      check("t5_count_kept", 32'(pop_count), 32'd0);
      check("t5_resume", 32'(rd_if.o_fifo_rd_en), 32'd1);
      check("t5_fifo_left", 32'(fcnt), 32'd13);
      step();
      rd_if.i_m_ready = 1'b1;
      wait_valid("t5_next_valid", 10);
      check("t5_next_word", 32'(rd_if.o_m_data), 32'h03);
      wait_drain("t5_drain", 40);
      check("t5_count", 32'(pop_count), 32'd13);

      // Reset in the middle of a stream, then a single fresh word.
      step();
      do_reset(1);
      rd_if.i_m_ready = 1'b0;
      for (int i = 0; i < 16; i++) fifo_write(8'(8'h80 + i));
      step();
      rd_if.i_m_ready = 1'b1;
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while ((pop_count != 5'd5) && (n < 40));
         check("t6_reach5", 32'(pop_count), 32'd5);
      end
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check("t6_rst_valid", 32'(rd_if.o_m_valid), 32'd0);
      check("t6_rst_count", 32'(pop_count), 32'd0);
      check("t6_rst_rd_en", 32'(rd_if.o_fifo_rd_en), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t6_post_valid", 32'(rd_if.o_m_valid), 32'd0);
      check("t6_post_rd_en", 32'(rd_if.o_fifo_rd_en), 32'd0);
      step();
      fifo_write(8'hA5);
      wait_drain("t6_drain", 20);
      repeat (5) @(negedge clk);
      check("t6_single", 32'(pop_count), 32'd1);

      // Long stream that wraps the counter, with a flush while a handshake is completing.
      step();
      do_reset(1);
      rd_if.i_m_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         flush = (i == 25);
         fifo_write(8'(8'h40 + i));
         flush = 1'b0;
      end
      wait_drain("t7_drain", 40);
      check("t7_wrapped", 32'(hs_all > 32), 32'd1);
      check("t7_count_wrap", 32'(pop_count), 32'(hs_all % 32));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
